// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID pipeline stage: the occupancy state encoding
// and the MIPS instruction field bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // count register, held once saturated
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with optional 2-entry skid buffer, MIPS field decode
// of the head entry and saturating stall/flush performance counters.
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     in_pc_plus_4,
  input  logic [INSTR_W-1:0]  in_instruction,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc_plus_4,
  output logic [5:0]          out_opcode,
  output logic [4:0]          out_rs,
  output logic [4:0]          out_rt,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_shamt,
  output logic [5:0]          out_funct,
  output logic [15:0]         out_imm16,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PC_W-1:0]      r_main_pc;
  logic [PC_W-1:0]      r_skid_pc;
  logic [PC_W-1:0]      w_main_pc_nxt;
  logic [PC_W-1:0]      w_skid_pc_nxt;
  logic [INSTR_W-1:0]   r_main_ins;
  logic [INSTR_W-1:0]   r_skid_ins;
  logic [INSTR_W-1:0]   w_main_ins_nxt;
  logic [INSTR_W-1:0]   w_skid_ins_nxt;
  logic [INSTR_W-1:0]   w_head_ins;
  logic                 r_in_ready;
  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_stall_inc;
  logic                 w_flush_inc;

  assign w_out_valid = (r_state != ST_EMPTY);
  // Without the skid entry, ready must look through to the consumer to keep full rate.
  assign w_in_ready  = SKID_EN ? r_in_ready : (out_ready | ~w_out_valid);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  // next-state and payload selection; flush overrides every transition
  always_comb begin
    w_state_nxt    = r_state;
    w_main_pc_nxt  = r_main_pc;
    w_main_ins_nxt = r_main_ins;
    w_skid_pc_nxt  = r_skid_pc;
    w_skid_ins_nxt = r_skid_ins;
    if (flush) begin
      w_state_nxt    = ST_EMPTY;
      w_main_pc_nxt  = '0;
      w_main_ins_nxt = '0;
      w_skid_pc_nxt  = '0;
      w_skid_ins_nxt = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt    = ST_FULL;
            w_main_pc_nxt  = in_pc_plus_4;
            w_main_ins_nxt = in_instruction;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_in_fire && w_out_fire) begin
            w_main_pc_nxt  = in_pc_plus_4;
            w_main_ins_nxt = in_instruction;
          end else if (w_in_fire && SKID_EN) begin
            w_state_nxt    = ST_SKID;
            w_skid_pc_nxt  = in_pc_plus_4;
            w_skid_ins_nxt = in_instruction;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        ST_SKID: begin
          if (w_out_fire) begin
            w_state_nxt    = ST_FULL;
            w_main_pc_nxt  = r_skid_pc;
            w_main_ins_nxt = r_skid_ins;
            w_skid_pc_nxt  = '0;
            w_skid_ins_nxt = '0;
          end else begin
            w_state_nxt = ST_SKID;
          end
        end
        default: begin
          w_state_nxt    = ST_EMPTY;
          w_main_pc_nxt  = '0;
          w_main_ins_nxt = '0;
          w_skid_pc_nxt  = '0;
          w_skid_ins_nxt = '0;
        end
      endcase
    end
  end

  // state, payload and registered ready
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_main_pc  <= '0;
      r_main_ins <= '0;
      r_skid_pc  <= '0;
      r_skid_ins <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main_pc  <= w_main_pc_nxt;
      r_main_ins <= w_main_ins_nxt;
      r_skid_pc  <= w_skid_pc_nxt;
      r_skid_ins <= w_skid_ins_nxt;
      r_in_ready <= (w_state_nxt != ST_SKID);
    end
  end

  // Bubbles present as all-zero payload so ID sees a NOP.
  assign w_head_ins    = w_out_valid ? r_main_ins : '0;
  assign out_pc_plus_4 = w_out_valid ? r_main_pc : '0;
  assign out_opcode    = w_head_ins[OPCODE_HI:OPCODE_LO];
  assign out_rs        = w_head_ins[RS_HI:RS_LO];
  assign out_rt        = w_head_ins[RT_HI:RT_LO];
  assign out_rd        = w_head_ins[RD_HI:RD_LO];
  assign out_shamt     = w_head_ins[SHAMT_HI:SHAMT_LO];
  assign out_funct     = w_head_ins[FUNCT_HI:FUNCT_LO];
  assign out_imm16     = w_head_ins[IMM_HI:IMM_LO];
  assign out_valid     = w_out_valid;
  assign in_ready      = w_in_ready;

  // A flush only counts if something valid is lost; a head consumed that cycle is not lost.
  assign w_stall_inc = w_out_valid & ~out_ready;
  assign w_flush_inc = flush & (in_valid | (r_state == ST_SKID) | (w_out_valid & ~out_ready));

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall_inc),
    .o_count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_flush_inc),
    .o_count (flush_count)
  );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed vector table, hand sequences and random
// traffic against a queue-based reference model, for both SKID_EN settings.
module tb_if_id_skid_stage;

  localparam int CW = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic reset, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_ins;

  logic a_ov, a_ir, b_ov, b_ir;
  logic [31:0] a_pc, b_pc;
  logic [5:0] a_op, b_op, a_fn, b_fn;
  logic [4:0] a_rs, a_rt, a_rd, a_sh, b_rs, b_rt, b_rd, b_sh;
  logic [15:0] a_imm, b_imm;
  logic [CW-1:0] a_sc, a_fc, b_sc, b_fc;

  if_id_skid_stage #(.PC_W(32), .SKID_EN(1'b1), .CNT_W(CW)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ir),
    .in_pc_plus_4(in_pc), .in_instruction(in_ins), .flush(flush),
    .out_valid(a_ov), .out_ready(out_ready), .out_pc_plus_4(a_pc),
    .out_opcode(a_op), .out_rs(a_rs), .out_rt(a_rt), .out_rd(a_rd),
    .out_shamt(a_sh), .out_funct(a_fn), .out_imm16(a_imm),
    .stall_count(a_sc), .flush_count(a_fc));

  if_id_skid_stage #(.PC_W(32), .SKID_EN(1'b0), .CNT_W(CW)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_ir),
    .in_pc_plus_4(in_pc), .in_instruction(in_ins), .flush(flush),
    .out_valid(b_ov), .out_ready(out_ready), .out_pc_plus_4(b_pc),
    .out_opcode(b_op), .out_rs(b_rs), .out_rt(b_rt), .out_rd(b_rd),
    .out_shamt(b_sh), .out_funct(b_fn), .out_imm16(b_imm),
    .stall_count(b_sc), .flush_count(b_fc));

  always #5 clk = ~clk;

  logic        av[2], ar[2];
  logic [31:0] apc[2], ains[2];
  logic [15:0] aimm[2];
  logic [CW-1:0] asc[2], afc[2];

  assign av[0] = a_ov;  assign av[1] = b_ov;
  assign ar[0] = a_ir;  assign ar[1] = b_ir;
  assign apc[0] = a_pc; assign apc[1] = b_pc;
  assign ains[0] = {a_op, a_rs, a_rt, a_rd, a_sh, a_fn};
  assign ains[1] = {b_op, b_rs, b_rt, b_rd, b_sh, b_fn};
  assign aimm[0] = a_imm; assign aimm[1] = b_imm;
  assign asc[0] = a_sc; assign asc[1] = b_sc;
  assign afc[0] = a_fc; assign afc[1] = b_fc;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each instance is a FIFO of {pc,instr} with capacity 2 (skid) or 1.
  logic [63:0] mq[2][2];
  int mcnt[2];
  int msc[2];
  int mfc[2];
  bit mdl_ok = 1'b0;

  function automatic bit m_ready(input int k);
    if (k == 0) return (mcnt[k] < 2);
    return (mcnt[k] == 0) || out_ready;
  endfunction

  task automatic model_check();
    logic [63:0] head;
    if (mdl_ok) begin
      for (int k = 0; k < 2; k++) begin
        head = (mcnt[k] > 0) ? mq[k][0] : 64'd0;
        chk($sformatf("m%0d_out_valid", k), {63'd0, av[k]}, {63'd0, mcnt[k] > 0});
        chk($sformatf("m%0d_in_ready", k), {63'd0, ar[k]}, {63'd0, m_ready(k)});
        chk($sformatf("m%0d_pc", k), {32'd0, apc[k]}, {32'd0, head[63:32]});
        chk($sformatf("m%0d_instr", k), {32'd0, ains[k]}, {32'd0, head[31:0]});
        chk($sformatf("m%0d_imm16", k), {48'd0, aimm[k]}, {48'd0, head[15:0]});
        chk($sformatf("m%0d_stall_count", k), {60'd0, asc[k]}, 64'(msc[k]));
        chk($sformatf("m%0d_flush_count", k), {60'd0, afc[k]}, 64'(mfc[k]));
      end
    end
  endtask

  task automatic model_update();
    bit rdy, infire, ofire;
    if (reset) begin
      mdl_ok = 1'b1;
      for (int k = 0; k < 2; k++) begin
        mcnt[k] = 0; msc[k] = 0; mfc[k] = 0;
      end
    end else if (mdl_ok) begin
      for (int k = 0; k < 2; k++) begin
        rdy = m_ready(k);
        infire = in_valid && rdy;
        ofire = (mcnt[k] > 0) && out_ready;
        if ((mcnt[k] > 0) && !out_ready && (msc[k] < SAT)) msc[k]++;
        if (flush && (in_valid || (mcnt[k] - (ofire ? 1 : 0)) > 0) && (mfc[k] < SAT)) mfc[k]++;
        if (flush) begin
          mcnt[k] = 0;
        end else begin
          if (ofire) begin
            mq[k][0] = mq[k][1];
            mcnt[k]--;
          end
          if (infire) begin
            mq[k][mcnt[k]] = {in_pc, in_ins};
            mcnt[k]++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_check();
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic iv, input logic fl, input logic ordy,
                       input logic [31:0] pc, input logic [31:0] ins);
    reset = r; in_valid = iv; flush = fl; out_ready = ordy; in_pc = pc; in_ins = ins;
  endtask

  typedef struct {
    logic rst, iv, fl, ordy;
    logic [31:0] pc, ins;
    logic chk_en, ev, er;
    logic [31:0] epc, eins;
    logic [3:0] esc, efc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic iv, input logic fl, input logic ordy,
                     input logic [31:0] pc, input logic [31:0] ins, input logic ce,
                     input logic ev, input logic er, input logic [31:0] epc,
                     input logic [31:0] eins, input logic [3:0] esc, input logic [3:0] efc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.fl = fl; v.ordy = ordy; v.pc = pc; v.ins = ins;
    v.chk_en = ce; v.ev = ev; v.er = er; v.epc = epc; v.eins = eins; v.esc = esc; v.efc = efc;
    tbl.push_back(v);
  endtask

  logic [31:0] stream_ins[8];

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // rst iv fl ordy pc ins | chk valid ready pc instr stall flush  (observed on DUT A before the edge)
    add(1, 0, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 32'h0,        4'd0, 4'd0);
    add(0, 1, 0, 1, 32'h04, 32'h012A4020, 1, 0, 1, 32'h00, 32'h0,        4'd0, 4'd0);
    add(0, 0, 0, 1, 32'h00, 32'h0,        1, 1, 1, 32'h04, 32'h012A4020, 4'd0, 4'd0);
    add(0, 1, 0, 0, 32'h08, 32'h8C220004, 1, 0, 1, 32'h00, 32'h0,        4'd0, 4'd0);
    add(0, 1, 0, 0, 32'h0C, 32'h00432820, 1, 1, 1, 32'h08, 32'h8C220004, 4'd0, 4'd0);
    add(0, 1, 0, 0, 32'h10, 32'h20420001, 1, 1, 0, 32'h08, 32'h8C220004, 4'd1, 4'd0);
    add(0, 1, 0, 1, 32'h10, 32'h20420001, 1, 1, 0, 32'h08, 32'h8C220004, 4'd2, 4'd0);
    add(0, 1, 0, 1, 32'h10, 32'h20420001, 1, 1, 1, 32'h0C, 32'h00432820, 4'd2, 4'd0);
    add(0, 0, 0, 1, 32'h00, 32'h0,        1, 1, 1, 32'h10, 32'h20420001, 4'd2, 4'd0);
    add(0, 1, 0, 0, 32'h14, 32'h11111111, 1, 0, 1, 32'h00, 32'h0,        4'd2, 4'd0);
    add(0, 1, 0, 0, 32'h18, 32'h22222222, 1, 1, 1, 32'h14, 32'h11111111, 4'd2, 4'd0);
    add(0, 1, 1, 0, 32'h1C, 32'h33333333, 1, 1, 0, 32'h14, 32'h11111111, 4'd3, 4'd0);
    add(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 1, 32'h00, 32'h0,        4'd4, 4'd1);
    add(0, 1, 0, 0, 32'h20, 32'h44444444, 1, 0, 1, 32'h00, 32'h0,        4'd4, 4'd1);
    add(1, 1, 0, 0, 32'h24, 32'h55555555, 1, 1, 1, 32'h20, 32'h44444444, 4'd4, 4'd1);
    add(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 1, 32'h00, 32'h0,        4'd0, 4'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].fl, tbl[i].ordy, tbl[i].pc, tbl[i].ins);
      #1;
      if (tbl[i].chk_en) begin
        chk($sformatf("vec%0d_out_valid", i), {63'd0, a_ov}, {63'd0, tbl[i].ev});
        chk($sformatf("vec%0d_in_ready", i), {63'd0, a_ir}, {63'd0, tbl[i].er});
        chk($sformatf("vec%0d_pc", i), {32'd0, a_pc}, {32'd0, tbl[i].epc});
        chk($sformatf("vec%0d_fields", i), {32'd0, ains[0]}, {32'd0, tbl[i].eins});
        chk($sformatf("vec%0d_stall", i), {60'd0, a_sc}, {60'd0, tbl[i].esc});
        chk($sformatf("vec%0d_flush", i), {60'd0, a_fc}, {60'd0, tbl[i].efc});
        if (i == 2) begin
          chk("dec_rs", {59'd0, a_rs}, 64'd9);
          chk("dec_rt", {59'd0, a_rt}, 64'd10);
          chk("dec_rd", {59'd0, a_rd}, 64'd8);
          chk("dec_funct", {58'd0, a_fn}, 64'h20);
          chk("dec_opcode", {58'd0, a_op}, 64'd0);
        end
      end
      tick();
    end

    // 8 back-to-back instructions emerge on 8 consecutive cycles with ready held high.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        stream_ins[i] = $urandom;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h100 + 32'(4 * i), stream_ins[i]);
      end else begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      end
      #1;
      chk($sformatf("stream%0d_in_ready", i), {63'd0, a_ir}, 64'd1);
      if (i > 0) begin
        chk($sformatf("stream%0d_valid", i), {63'd0, a_ov}, 64'd1);
        chk($sformatf("stream%0d_pc", i), {32'd0, a_pc}, 64'h100 + 64'(4 * (i - 1)));
        chk($sformatf("stream%0d_instr", i), {32'd0, ains[0]}, {32'd0, stream_ins[i - 1]});
      end
      tick();
    end

    // stall counter saturation with a single held entry
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'hDEADBEEF);
    #1; tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      #1; tick();
    end
    #1;
    chk("stall_sat", {60'd0, a_sc}, 64'd15);
    tick();
    #1;
    chk("stall_sat_hold", {60'd0, a_sc}, 64'd15);
    chk("stall_sat_head", {32'd0, a_pc}, 64'h200);
    tick();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(99) == 0), ($urandom_range(9) < 7), ($urandom_range(11) == 0),
            ($urandom_range(9) < 6), $urandom, $urandom);
      #1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
